// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access / write-back stage: funct3 encodings,
// FSM state type and the access alignment rule.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    // Byte accesses are always aligned; halves need an even offset, words offset 0.
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic ok;
        case (funct3)
            3'b000, 3'b100: ok = 1'b1;
            3'b001, 3'b101: ok = ~offset[0];
            3'b010:         ok = (offset == 2'b00);
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half/word lane of a read word and sign- or
// zero-extends it to the 32-bit write-back value.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] wb_value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   wb_value = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  wb_value = {24'd0, byte_sel};
            F3_LH:   wb_value = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  wb_value = {16'd0, half_sel};
            F3_LW:   wb_value = rdata;
            default: wb_value = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_writeback.sv
// Memory-access and write-back stage: issues loads/stores over a req/ack port and
// produces registered register-file write-back; rejects misaligned/illegal accesses.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | accepting instructions; ALU results written back directly
//   ST_ACCESS | dmem request outstanding, all dmem_* held until ack
module mem_writeback
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       store_data,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              mem_err
);

    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic [4:0]         rd_q, rd_d;
    logic [2:0]         f3_q, f3_d;
    logic [1:0]         off_q, off_d;
    logic               wb_we_q, wb_we_d;
    logic [4:0]         wb_rd_q, wb_rd_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic               err_q, err_d;

    logic               is_mem;
    logic               f3_legal;
    logic               access_ok;
    logic [1:0]         off;
    logic [3:0]         be_fmt;
    logic [31:0]        wdata_fmt;
    logic [31:0]        ext_value;

    assign off = alu_result[1:0];

    always_comb begin
        is_mem = mem_read | mem_write;
        if (mem_read & mem_write) begin
            f3_legal = 1'b0;
        end else if (mem_read) begin
            f3_legal = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        end else begin
            f3_legal = funct3 inside {F3_SB, F3_SH, F3_SW};
        end
        access_ok = f3_legal & is_aligned(funct3, off);
    end

    // Byte enables are formed for loads too so the memory sees which lanes are read.
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                be_fmt    = 4'b0001 << off;
                wdata_fmt = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_fmt    = 4'b0011 << off;
                wdata_fmt = {2{store_data[15:0]}};
            end
            default: begin
                be_fmt    = 4'b1111;
                wdata_fmt = store_data;
            end
        endcase
    end

    load_extend u_load_extend (
        .rdata    (dmem_rdata),
        .funct3   (f3_q),
        .offset   (off_q),
        .wb_value (ext_value)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rd_d      = rd_q;
        f3_d      = f3_q;
        off_d     = off_q;
        wb_we_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        wb_we_d   = reg_write & (rd != 5'd0);
                        wb_rd_d   = rd;
                        wb_data_d = alu_result;
                    end else if (!access_ok) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        addr_d  = {alu_result[ADDR_W-1:2], 2'b00};
                        wdata_d = wdata_fmt;
                        be_d    = be_fmt;
                        rd_d    = rd;
                        f3_d    = funct3;
                        off_d   = off;
                    end
                end
            end
            ST_ACCESS: begin
                if (dmem_ack && req_q) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        wb_we_d   = (rd_q != 5'd0);
                        wb_rd_d   = rd_q;
                        wb_data_d = ext_value;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            rd_q      <= 5'd0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= 5'd0;
            wb_data_q <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rd_q      <= rd_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign mem_err    = err_q;

endmodule
